rr_mux_4_arb: RTL and testbench
===============================

Name: rr_mux_4_arb

Overview:
- Round-robin arbitrated 4:1 selector with valid/ready handshakes on all four inputs and on the output.
- Sits directly upstream of the datapath consumers of mux_4_1-style selection.
- Chooses one requesting channel per cycle, drives the select code, and registers the selected word into a 1-entry output stage.
- Replaces the free-running external sel with fair, back-pressure-aware selection.

Parameters:
WIDTH, 4, data width of each input channel and of out_data.

Ports:
clk       input   1      clock, all state updates on rising edge
rst       input   1      reset, asynchronous, active-high
in_valid  input   4      per-channel request; bit k qualifies in_data<k>
in_data0  input   WIDTH  channel 0 data
in_data1  input   WIDTH  channel 1 data
in_data2  input   WIDTH  channel 2 data
in_data3  input   WIDTH  channel 3 data
in_ready  output  4      one-hot or zero; bit k = channel k transferred this cycle
out_valid output  1      output register holds a word
out_ready input   1      downstream accepts out_data this cycle
out_data  output  WIDTH  registered selected word
out_sel   output  2      registered index of the channel that produced out_data

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset values (asserted immediately, no clock needed): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
- Reset mid-operation: any held word is discarded; no transfer completes in a cycle where rst is high; in_ready=0 while rst is high.
- Output stage: single register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid | out_ready (combinational).
- Arbitration, combinational: scan channels in order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first k with in_valid[k]=1 is the grant.
- Handshake: in_ready[k]=1 only when k is the grant and can_accept=1; otherwise 0. At most one in_ready bit is set per cycle.
- Transfer on channel k: in_valid[k] & in_ready[k]. At the next edge:
  - out_data <= in_data<k>
  - out_sel <= k
  - out_valid <= 1
  - ptr <= (k+1) mod 4; 2-bit wrap, so 3 -> 0.
- No transfer, out_valid & out_ready: out_valid <= 0; out_data and out_sel hold their last values.
- No transfer, out_valid & !out_ready (stall): out_valid, out_data and out_sel hold stable. Senders must keep in_valid and in_data stable until in_ready.
- Simultaneous drain and fill (out_valid & out_ready & a grant): the new word loads in the same edge. Sustained throughput is 1 word/cycle; latency is 1 cycle from input transfer to out_valid.
- ptr advances only on a transfer; it is unchanged on idle or stall cycles.
- in_ready may depend combinationally on in_valid and out_ready. in_valid must not depend on in_ready.
- No state other than ptr and the output register; no other FSM states.

Test Plan:
- Reset and idle: assert rst mid-burst with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately; after release with in_valid=0000 -> in_ready=0000, outputs unchanged.
- Single channel: in_valid=0100, in_data2=4'hA, out_ready=1 -> in_ready=0100; next cycle out_valid=1, out_data=A, out_sel=2; ptr=3.
- Round-robin fairness: in_valid=1111 held, data0..3=1,2,3,4, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1; one in_ready bit per cycle.
- Wrap-around priority: ptr=3 with in_valid=1001 -> channel 3 granted first, then channel 0; ptr goes 3 -> 0 -> 1.
- Back-pressure: out_valid=1, out_data=5, out_ready=0 for 3 cycles with in_valid=0010 -> in_ready=0000, out_data stays 5, ptr unchanged. Raising out_ready -> in_ready=0010 that cycle, and channel 1 data appears the next cycle.
- Drain without refill: out_valid=1, out_ready=1, in_valid=0000 -> next cycle out_valid=0, out_data/out_sel retain last values.

Source files
------------

// File: rtl/rr_mux_4_arb.sv
// -----------------------------------------------------------------------------
// rr_mux_4_arb
//   Round-robin arbitrated 4:1 selector. It grants one requesting channel per
//   cycle and registers the granted word into a single-entry output stage.
//   The grant is not a free-running select: it respects both fairness and
//   downstream back-pressure.
//
// Handshake rule (all five interfaces): a word moves on a rising edge when
// valid and ready are both high in the cycle before that edge. A sender holds
// valid and data stable until ready is seen. valid never depends on ready.
// ready may depend combinationally on valid (in_ready depends on in_valid and
// on out_ready).
//
// Ports
//   clk          clock; all state updates happen on its rising edge
//   rst          asynchronous, active-high reset
//   in_valid     per-channel request; bit k qualifies in_data<k>
//   in_data0..3  channel data words
//   in_ready     one-hot or zero; bit k is high when channel k transfers
//   out_valid    output register holds a word
//   out_ready    downstream accepts out_data this cycle
//   out_data     registered selected word
//   out_sel      registered index of the channel that produced out_data
//   o_dbg_state  output-stage state (0 = EMPTY, 1 = FULL)
//   o_dbg_ptr    round-robin pointer (highest-priority channel this cycle)
// -----------------------------------------------------------------------------
module rr_mux_4_arb #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       in_valid,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   input  logic [WIDTH-1:0] in_data3,
   output logic [3:0]       in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_sel,
   output logic             o_dbg_state,
   output logic [1:0]       o_dbg_ptr
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_ptr;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_sel;

   logic             w_can_accept;
   logic             w_grant_vld;
   logic [1:0]       w_grant_idx;
   logic             w_xfer;
   logic [WIDTH-1:0] w_grant_data;

   // The output register can take a new word when it is empty or is being
   // drained in this same cycle.
   assign w_can_accept = (r_state == ST_EMPTY) || out_ready;

   // Round-robin scan: the loop runs from the farthest offset down to offset
   // 0, so the requester closest to r_ptr is the last one written and wins.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = r_ptr;
      for (int i = 3; i >= 0; i--) begin
         if (in_valid[r_ptr + 2'(i)]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = r_ptr + 2'(i);
         end
      end
   end

   // While reset is high no handshake is offered, so no transfer can complete.
   always_comb begin
      in_ready = 4'b0000;
      if (!rst && w_grant_vld && w_can_accept) begin
         in_ready[w_grant_idx] = 1'b1;
      end
   end

   assign w_xfer = |in_ready;

   always_comb begin
      case (w_grant_idx)
         2'd0:    w_grant_data = in_data0;
         2'd1:    w_grant_data = in_data1;
         2'd2:    w_grant_data = in_data2;
         default: w_grant_data = in_data3;
      endcase
   end

   // Output-stage next state. A fill takes priority over a drain, so a word
   // can be drained and replaced on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      if (w_xfer) begin
         w_state_nxt = ST_FULL;
      end else if ((r_state == ST_FULL) && out_ready) begin
         w_state_nxt = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Data, select and pointer change only on a transfer. On a drain or a
   // stall, out_data and out_sel keep their last values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_sel  <= 2'd0;
         r_ptr  <= 2'd0;
      end else if (w_xfer) begin
         r_data <= w_grant_data;
         r_sel  <= w_grant_idx;
         r_ptr  <= w_grant_idx + 2'd1;
      end
   end

   assign out_valid   = (r_state == ST_FULL);
   assign out_data    = r_data;
   assign out_sel     = r_sel;
   assign o_dbg_state = r_state;
   assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_rr_mux_4_arb.sv
module tb_rr_mux_4_arb;

   localparam int WIDTH = 4;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       in_valid;
   logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
   logic [3:0]       in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_sel;
   logic             dbg_state;
   logic [1:0]       dbg_ptr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rr_mux_4_arb #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data0    (in_data0),
      .in_data1    (in_data1),
      .in_data2    (in_data2),
      .in_data3    (in_data3),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_sel     (out_sel),
      .o_dbg_state (dbg_state),
      .o_dbg_ptr   (dbg_ptr)
   );

   // ---------------- driver / check tasks ----------------
   // Advance one edge and sample 1 ns later, away from the active edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Registered outputs plus pointer, all in one call.
   task automatic chk_out(input string tag, input logic v, input logic [3:0] d,
                          input logic [1:0] s, input logic [1:0] p);
      chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, v});
      chk({tag, ".out_data"},  {4'd0, out_data},  {4'd0, d});
      chk({tag, ".out_sel"},   {6'd0, out_sel},   {6'd0, s});
      chk({tag, ".ptr"},       {6'd0, dbg_ptr},   {6'd0, p});
   endtask

   task automatic chk_rdy(input string tag, input logic [3:0] exp);
      chk({tag, ".in_ready"}, {4'd0, in_ready}, {4'd0, exp});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
      in_data0 = 4'h0; in_data1 = 4'h0; in_data2 = 4'h0; in_data3 = 4'h0;
      #1;
      chk_out("reset0", 1'b0, 4'h0, 2'd0, 2'd0);
      chk_rdy("reset0", 4'b0000);
      chk("reset0.state", {7'd0, dbg_state}, 8'd0);
      cyc(); cyc();
      rst = 1'b0; in_valid = 4'b0000;

      // Idle after reset: no request, so no grant and no state change.
      #1; chk_rdy("idle", 4'b0000);
      cyc(); chk_out("idle", 1'b0, 4'h0, 2'd0, 2'd0);

      // Single channel 2.
      in_valid = 4'b0100; in_data2 = 4'hA; out_ready = 1'b1;
      #1; chk_rdy("single", 4'b0100);
      cyc(); chk_out("single", 1'b1, 4'hA, 2'd2, 2'd3);

      // Wrap-around: ptr=3, channels 3 and 0 request. 3 wins, then 0.
      in_valid = 4'b1001; in_data3 = 4'h7; in_data0 = 4'h9;
      #1; chk_rdy("wrap1", 4'b1000);
      cyc(); chk_out("wrap1", 1'b1, 4'h7, 2'd3, 2'd0);
      chk_rdy("wrap2", 4'b0001);
      cyc(); chk_out("wrap2", 1'b1, 4'h9, 2'd0, 2'd1);

      // Drain without refill.
      in_valid = 4'b0000;
      #1; chk_rdy("drain", 4'b0000);
      cyc(); chk_out("drain", 1'b0, 4'h9, 2'd0, 2'd1);

      // Back-pressure. Load 5 from channel 0; the empty stage accepts even
      // with out_ready low.
      in_valid = 4'b0001; in_data0 = 4'h5; out_ready = 1'b0;
      #1; chk_rdy("bp_load", 4'b0001);
      cyc(); chk_out("bp_load", 1'b1, 4'h5, 2'd0, 2'd1);
      in_valid = 4'b0010; in_data1 = 4'hC;
      for (int k = 0; k < 3; k++) begin
         #1; chk_rdy("bp_stall", 4'b0000);
         cyc(); chk_out("bp_stall", 1'b1, 4'h5, 2'd0, 2'd1);
      end
      out_ready = 1'b1;
      #1; chk_rdy("bp_release", 4'b0010);
      cyc(); chk_out("bp_release", 1'b1, 4'hC, 2'd1, 2'd2);

      // Reset mid-burst while a word is held and requests are pending.
      in_valid = 4'b1111;
      rst = 1'b1;
      #1;
      chk_out("midrst", 1'b0, 4'h0, 2'd0, 2'd0);
      chk_rdy("midrst", 4'b0000);
      cyc(); chk_out("midrst_edge", 1'b0, 4'h0, 2'd0, 2'd0);
      rst = 1'b0;

      // Fairness: all four request, each is served in turn.
      in_data0 = 4'h1; in_data1 = 4'h2; in_data2 = 4'h3; in_data3 = 4'h4;
      out_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk_rdy("rr", 4'b0001 << (k % 4));
         cyc();
         chk_out("rr", 1'b1, 4'((k % 4) + 1), 2'(k % 4), 2'((k + 1) % 4));
      end
      in_valid = 4'b0000;
      cyc();
      chk_out("rr_drain", 1'b0, 4'h1, 2'd0, 2'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
